// File: rtl/video_pkg.sv
// Shared video-subsystem types and register constants for the OAM DMA engine.
// Constants double as parameter defaults for blocks that address the PPU/CPU register maps.
package video_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [2:0]  PPU_REG_OAM_DATA = 3'd4;
    localparam logic [15:0] CPU_REG_OAM_DMA  = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies one 256-byte CPU page into the PPU OAM data register.
// One byte per get/put tick pair; state only moves on I_cpu_ce, gaps in the strobe stretch every state.
module oam_dma
    import video_pkg::*;
#(
    parameter logic [15:0] P_DMA_REG      = CPU_REG_OAM_DMA,
    parameter logic [2:0]  P_OAM_DATA_REG = PPU_REG_OAM_DATA
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cpu_ce,
    input  logic [15:0] I_cpu_addr,
    input  logic        I_cpu_wren,
    input  logic [7:0]  I_cpu_data,
    output logic        O_cpu_halt,
    output logic        O_busy,
    output logic [15:0] O_dma_addr,
    output logic        O_dma_rden,
    input  logic [7:0]  I_dma_data,
    output logic [2:0]  O_ppu_addr,
    output logic        O_ppu_wren,
    output logic [7:0]  O_ppu_data
);

    dma_state_t state_q, state_d;
    logic       par_q, par_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q <= IDLE;
            par_q   <= 1'b0;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        par_d      = par_q ^ I_cpu_ce;
        idx_d      = idx_q;
        page_d     = page_q;
        data_d     = data_q;
        O_dma_addr = 16'h0000;
        O_dma_rden = 1'b0;
        O_ppu_addr = 3'd0;
        O_ppu_wren = 1'b0;
        O_ppu_data = 8'h00;

        case (state_q)
            IDLE: begin
                if (I_cpu_ce && I_cpu_wren && (I_cpu_addr == P_DMA_REG)) begin
                    page_d  = I_cpu_data;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                // The next tick is a get tick exactly when this one is a put tick.
                if (I_cpu_ce) state_d = par_q ? READ : ALIGN;
            end
            ALIGN: begin
                if (I_cpu_ce) state_d = READ;
            end
            READ: begin
                O_dma_rden = 1'b1;
                O_dma_addr = {page_q, idx_q};
                if (I_cpu_ce) begin
                    data_d  = I_dma_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                O_ppu_addr = P_OAM_DATA_REG;
                O_ppu_data = data_q;
                O_ppu_wren = I_cpu_ce;
                if (I_cpu_ce) begin
                    if (idx_q == 8'hFF) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign O_busy     = (state_q != IDLE);
    assign O_cpu_halt = O_busy;

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma: tick-level driver, byte-sequence reference model, per-scenario checks.
module tb_oam_dma;

    logic        I_clock = 1'b0;
    logic        I_reset;
    logic        I_cpu_ce;
    logic [15:0] I_cpu_addr;
    logic        I_cpu_wren;
    logic [7:0]  I_cpu_data;
    logic        O_cpu_halt;
    logic        O_busy;
    logic [15:0] O_dma_addr;
    logic        O_dma_rden;
    logic [7:0]  I_dma_data;
    logic [2:0]  O_ppu_addr;
    logic        O_ppu_wren;
    logic [7:0]  O_ppu_data;

    oam_dma dut (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .I_cpu_ce  (I_cpu_ce),
        .I_cpu_addr(I_cpu_addr),
        .I_cpu_wren(I_cpu_wren),
        .I_cpu_data(I_cpu_data),
        .O_cpu_halt(O_cpu_halt),
        .O_busy    (O_busy),
        .O_dma_addr(O_dma_addr),
        .O_dma_rden(O_dma_rden),
        .I_dma_data(I_dma_data),
        .O_ppu_addr(O_ppu_addr),
        .O_ppu_wren(O_ppu_wren),
        .O_ppu_data(O_ppu_data)
    );

    always #5 I_clock = ~I_clock;

    // CPU memory image: byte at any address is addr[7:0]^5A; garbage when nobody reads.
    assign I_dma_data = O_dma_rden ? (O_dma_addr[7:0] ^ 8'h5A) : 8'hEE;

    int n_cmp  = 0;
    int n_fail = 0;

    int ticks;          // CPU ticks since reset release; parity model of the get/put phase
    int trig_tick;
    int trig_par;
    int halted;
    int first_rd_tick;
    int viol;
    int timeout;
    int stopped;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic [29:0] prev_snap;
    logic        prev_ce;
    logic        have_prev;

    // One clock: apply inputs, observe outputs mid-cycle, advance past the edge.
    task automatic cyc(input logic ce, input logic wr, input logic [15:0] a, input logic [7:0] d);
        logic [29:0] snap;
        I_cpu_ce   = ce;
        I_cpu_wren = wr;
        I_cpu_addr = a;
        I_cpu_data = d;
        #1;
        snap = {O_cpu_halt, O_busy, O_dma_addr, O_dma_rden, O_ppu_addr, O_ppu_data};
        if (have_prev && !prev_ce && snap !== prev_snap) viol++;
        if (!ce && O_ppu_wren !== 1'b0) viol++;
        if (!O_dma_rden && O_dma_addr !== 16'h0000) viol++;
        if (O_cpu_halt !== O_busy) viol++;
        if (!O_busy && (O_dma_rden | O_ppu_wren) !== 1'b0) viol++;
        if (O_ppu_wren === 1'b1) begin
            wr_q.push_back(O_ppu_data);
            if (O_ppu_addr !== 3'd4) viol++;
        end
        if (ce && O_dma_rden === 1'b1) begin
            if (rd_q.size() == 0) first_rd_tick = ticks - trig_tick;
            rd_q.push_back(O_dma_addr);
        end
        if (ce && O_busy === 1'b1) halted++;
        prev_snap = snap;
        prev_ce   = ce;
        have_prev = 1'b1;
        @(posedge I_clock);
        #1;
        if (ce && I_reset) ticks++;
        I_cpu_ce   = 1'b0;
        I_cpu_wren = 1'b0;
    endtask

    task automatic tick_gap(input int lo, input int hi, input logic wr,
                            input logic [15:0] a, input logic [7:0] d);
        int n;
        n = $urandom_range(hi, lo);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b1, wr, a, d);
    endtask

    // Triggers a transfer on a tick of the requested parity and runs it to completion
    // (or until the READ of byte stop_read is on the bus).
    task automatic drive_transfer(input logic [7:0] pg, input int want_par, input int lo,
                                  input int hi, input int retrig_byte, input int stop_read);
        int budget;
        int n;
        rd_q.delete();
        wr_q.delete();
        halted = 0; viol = 0; timeout = 0; stopped = 0;
        first_rd_tick = -1; have_prev = 1'b0; prev_ce = 1'b1;
        while ((ticks % 2) != want_par) tick_gap(lo, hi, 1'b0, 16'h0000, 8'h00);
        trig_par  = ticks % 2;
        trig_tick = ticks;
        tick_gap(lo, hi, 1'b1, 16'h4014, pg);
        budget = 0;
        while (O_busy === 1'b1 && budget < 30000) begin
            if (stop_read >= 0 && O_dma_rden === 1'b1 && rd_q.size() == stop_read) begin
                stopped = 1;
                return;
            end
            n = $urandom_range(hi, lo);
            for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
            if (retrig_byte >= 0 && wr_q.size() == retrig_byte)
                cyc(1'b1, 1'b1, 16'h4014, 8'h07);
            else
                cyc(1'b1, 1'b0, 16'h0000, 8'h00);
            budget += n + 1;
        end
        if (budget >= 30000) timeout = 1;
        for (int k = 0; k < 4; k++) tick_gap(lo, hi, 1'b0, 16'h0000, 8'h00);
    endtask

    // Reference: byte i is read from {page,i} and written as i^5A.
    function automatic int seq_errors(input logic [7:0] pg);
        int e;
        e = 0;
        if (rd_q.size() != 256 || wr_q.size() != 256) return 1000;
        for (int i = 0; i < 256; i++) begin
            if (rd_q[i] !== {pg, 8'(i)}) e++;
            if (wr_q[i] !== (8'(i) ^ 8'h5A)) e++;
        end
        return e;
    endfunction

    task automatic test_reset;
        logic [31:0] outs;
        I_reset = 1'b0; I_cpu_ce = 1'b0; I_cpu_wren = 1'b0;
        I_cpu_addr = 16'h0000; I_cpu_data = 8'h00;
        repeat (3) @(posedge I_clock);
        #1;
        outs = {O_cpu_halt, O_busy, O_dma_addr, O_dma_rden, O_ppu_addr, O_ppu_wren, O_ppu_data};
        n_cmp++;
        if (outs !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        // Trigger presented while reset is held must not start anything.
        I_cpu_ce = 1'b1; I_cpu_wren = 1'b1; I_cpu_addr = 16'h4014; I_cpu_data = 8'h09;
        @(posedge I_clock);
        #1;
        I_cpu_ce = 1'b0; I_cpu_wren = 1'b0;
        n_cmp++;
        if (O_busy !== 1'b0) begin
            n_fail++; $display("FAIL trigger_in_reset: busy got %b want 0", O_busy);
        end
        I_reset = 1'b1;
        ticks = 0;
        #1;
        n_cmp++;
        if (O_busy !== 1'b0) begin
            n_fail++; $display("FAIL after_release: busy got %b want 0", O_busy);
        end
    endtask

    task automatic test_even;
        int e;
        drive_transfer(8'h02, 0, 3, 3, -1, -1);
        e = seq_errors(8'h02);
        n_cmp++; if (timeout != 0) begin n_fail++; $display("FAIL even_timeout: got %0d want 0", timeout); end
        n_cmp++; if (halted != 513) begin n_fail++; $display("FAIL even_halted: got %0d want 513", halted); end
        n_cmp++; if (first_rd_tick != 2) begin n_fail++; $display("FAIL even_first_read: got T%0d want T2", first_rd_tick); end
        n_cmp++; if (wr_q.size() != 256) begin n_fail++; $display("FAIL even_wren_count: got %0d want 256", wr_q.size()); end
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL even_sequence: got %0d errors want 0", e); end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL even_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_odd;
        int e;
        drive_transfer(8'h02, 1, 3, 3, -1, -1);
        e = seq_errors(8'h02);
        n_cmp++; if (halted != 514) begin n_fail++; $display("FAIL odd_halted: got %0d want 514", halted); end
        n_cmp++; if (first_rd_tick != 3) begin n_fail++; $display("FAIL odd_first_read: got T%0d want T3", first_rd_tick); end
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL odd_sequence: got %0d errors want 0", e); end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL odd_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_retrigger;
        int e;
        int p;
        p = $urandom_range(1, 0);
        drive_transfer(8'h02, p, 3, 3, 40, -1);
        e = seq_errors(8'h02);
        n_cmp++;
        if (halted != (trig_par == 0 ? 513 : 514)) begin
            n_fail++; $display("FAIL retrig_halted: got %0d want %0d", halted, trig_par == 0 ? 513 : 514);
        end
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL retrig_sequence: got %0d errors want 0", e); end
        n_cmp++; if (O_busy !== 1'b0) begin n_fail++; $display("FAIL retrig_restart: busy got %b want 0", O_busy); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] outs;
        int e;
        drive_transfer(8'h02, $urandom_range(1, 0), 3, 3, -1, 100);
        n_cmp++; if (stopped != 1) begin n_fail++; $display("FAIL mid_reach_byte100: got %0d want 1", stopped); end
        I_reset = 1'b0;
        #1;
        outs = {O_cpu_halt, O_busy, O_dma_addr, O_dma_rden, O_ppu_addr, O_ppu_wren, O_ppu_data};
        n_cmp++; if (outs !== 32'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
        n_cmp++; if (wr_q.size() != 100) begin n_fail++; $display("FAIL mid_partial_writes: got %0d want 100", wr_q.size()); end
        repeat (3) @(posedge I_clock);
        #1;
        I_reset = 1'b1;
        ticks = 0;
        drive_transfer(8'h03, $urandom_range(1, 0), 3, 3, -1, -1);
        e = seq_errors(8'h03);
        n_cmp++;
        if (halted != (trig_par == 0 ? 513 : 514)) begin
            n_fail++; $display("FAIL mid_fresh_halted: got %0d want %0d", halted, trig_par == 0 ? 513 : 514);
        end
        n_cmp++; if (e != 0) begin n_fail++; $display("FAIL mid_fresh_sequence: got %0d errors want 0", e); end
    endtask

    task automatic test_irregular;
        int e;
        for (int p = 0; p < 2; p++) begin
            drive_transfer(8'(8'h40 + p), p, 1, 7, -1, -1);
            e = seq_errors(8'(8'h40 + p));
            n_cmp++;
            if (halted != (p == 0 ? 513 : 514)) begin
                n_fail++; $display("FAIL irr%0d_halted: got %0d want %0d", p, halted, p == 0 ? 513 : 514);
            end
            n_cmp++; if (e != 0) begin n_fail++; $display("FAIL irr%0d_sequence: got %0d errors want 0", p, e); end
            n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL irr%0d_protocol: got %0d violations want 0", p, viol); end
        end
    endtask

    task automatic test_non_trigger;
        logic [15:0] addrs [3];
        logic        wrs   [3];
        int          seen;
        addrs[0] = 16'h4015; wrs[0] = 1'b1;
        addrs[1] = 16'h2004; wrs[1] = 1'b1;
        addrs[2] = 16'h4014; wrs[2] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            seen = 0;
            tick_gap(0, 3, wrs[s], addrs[s], 8'h02);
            for (int k = 0; k < 6; k++) begin
                tick_gap(0, 3, 1'b0, 16'h0000, 8'h00);
                if (O_busy !== 1'b0) seen++;
            end
            n_cmp++;
            if (seen != 0) begin
                n_fail++; $display("FAIL non_trigger_%h: busy seen %0d ticks want 0", addrs[s], seen);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ticks = 0;
        have_prev = 1'b0;
        prev_ce = 1'b1;
        prev_snap = '0;
        test_reset();
        test_non_trigger();
        test_even();
        test_odd();
        test_retrigger();
        test_reset_mid();
        test_irregular();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-attribute DMA engine sitting directly upstream of the PPU register port. On a CPU write to the DMA page register it halts the CPU and copies 256 bytes from CPU page `$XX00–$XXFF` into the PPU OAM data register (register 4), one byte per read/write tick pair. Its PPU-side outputs feed the PPU host port (addr/wren/data) through the top-level bus mux, which selects this block whenever `O_busy` is high.

## Interface
- `P_DMA_REG`, default 16'h4014: CPU address that triggers a transfer.
- `P_OAM_DATA_REG`, default 3'd4: PPU register index written with each byte.
- `I_clock` in 1: system clock; the only clock.
- `I_reset` in 1: asynchronous, active-low reset.
- `I_cpu_ce` in 1: one-clock strobe marking each CPU cycle (tick).
- `I_cpu_addr` in 16: CPU address bus.
- `I_cpu_wren` in 1: CPU write strobe, qualified by `I_cpu_ce`.
- `I_cpu_data` in 8: CPU write data.
- `O_cpu_halt` out 1: stalls the CPU while high.
- `O_busy` out 1: DMA owns the bus; drives the top-level mux select.
- `O_dma_addr` out 16: CPU-bus read address.
- `O_dma_rden` out 1: CPU-bus read enable.
- `I_dma_data` in 8: CPU-bus read data, valid at the `I_cpu_ce` that ends the READ tick.
- `O_ppu_addr` out 3: PPU register select.
- `O_ppu_wren` out 1: PPU register write; exactly one `I_clock` per byte.
- `O_ppu_data` out 8: byte written to OAM data.

## Operation
- State machine: IDLE → HALT → (ALIGN) → READ ↔ WRITE → IDLE. State advances only on clocks where `I_cpu_ce`=1. All other clocks hold state.
- Parity flop `par` toggles on every `I_cpu_ce`. It resets to 0. Ticks with `par`=0 are get ticks; ticks with `par`=1 are put ticks. `par` runs in every state, including IDLE.
- **IDLE:** on `I_cpu_ce & I_cpu_wren & I_cpu_addr==P_DMA_REG`:
  - latch `page` ← `I_cpu_data`;
  - clear `idx`[7:0];
  - go to HALT.
- **HALT:** lasts one tick. Next state is READ if the next tick is a get tick; otherwise ALIGN.
- **ALIGN:** lasts one tick, then READ.
- **READ:** lasts one tick, and always falls on a get tick.
  - `O_dma_addr` = {`page`,`idx`}; `O_dma_rden`=1.
  - At the closing `I_cpu_ce`, latch `data` ← `I_dma_data`, then go to WRITE.
- **WRITE:** lasts one tick, on a put tick.
  - `O_ppu_addr`=`P_OAM_DATA_REG`; `O_ppu_data`=`data`.
  - `O_ppu_wren` = `I_cpu_ce` (single-clock pulse at the end of the tick).
  - Then: if `idx`==8'hFF go to IDLE; else `idx`+1 and go to READ.
- `O_cpu_halt` = `O_busy` = (state ≠ IDLE).
- Outside READ, `O_dma_rden`=0 and `O_dma_addr`=0. Outside WRITE, `O_ppu_wren`=0.
- Writes to `P_DMA_REG` while busy are ignored: `page` is not reloaded and the transfer is not restarted.
- `idx` is 8 bits. The increment at 8'hFF never happens because the state exits first, so there is no wrap into the next page.

## Timing
- Reset (async, `I_reset`=0) values:
  - state IDLE; `par`=0; `page`, `idx`, `data` = 0;
  - all outputs 0.
- Reset mid-transfer: outputs drop to 0 immediately, with no partial PPU write. The next trigger starts a fresh transfer at `idx`=0.
- Let T0 be the trigger tick.
  - HALT is T1.
  - If `par` at T2 is 0: READ at T2 and last WRITE at T513, for 513 halted ticks.
  - Otherwise ALIGN at T2 and last WRITE at T514, for 514 halted ticks.
- Read-to-write latency is one tick. There are exactly 256 `O_ppu_wren` pulses per transfer.
- Gaps in `I_cpu_ce` stretch each state; outputs stay stable during a gap.
- Trigger and reset release in the same clock: reset wins.

## Structure
- Shared package `video_pkg` holds:
  - the `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE);
  - the constants `PPU_REG_OAM_DATA`=3'd4 and `CPU_REG_OAM_DMA`=16'h4014, which serve as parameter defaults.
- No sub-module. One single-file module with a registered state/`par`/`idx`/`page`/`data` block and a combinational next-state/output block.

## Test plan
- **Even-parity trigger:** write 8'h02 to 16'h4014 with `par`(T2)=0, `I_cpu_ce` every 4 clocks → 513 halted ticks; reads 16'h0200..16'h02FF in order; 256 `O_ppu_wren` pulses, each carrying the preceding read byte (memory preloaded with `addr[7:0]^8'h5A`); `O_ppu_addr`=4.
- **Odd-parity trigger:** same as the even case, one tick later → one ALIGN tick; 514 halted ticks; data identical.
- **Re-trigger while busy:** write 8'h07 to 16'h4014 at byte 40 → ignored; addresses stay on page 8'h02; transfer ends on schedule.
- **Reset mid-transfer:** assert `I_reset`=0 during the READ of byte 100 → all outputs 0 at once, `O_cpu_halt`=0; after release, a trigger with 8'h03 performs a full 256-byte transfer from 16'h0300.
- **Irregular `I_cpu_ce`:** random 1–7 clock gaps → the same 513/514 tick count; exactly one `O_ppu_wren` clock per byte; outputs stable during gaps.
- **Non-trigger addresses:** writes to 16'h4015 and 16'h2004, and a read of 16'h4014 → no transfer; `O_busy` stays 0.
